// File: rtl/calculator_pkg.sv
// Shared parameters, state/op encodings and address-range helper for the SRAM arithmetic engine.
package calculator_pkg;

    localparam int DATA_W        = 32;
    localparam int MEM_WORD_SIZE = 64;
    localparam int ADDR_W        = 10;
    localparam int NUM_CHUNKS    = MEM_WORD_SIZE / DATA_W;
    localparam int CHUNK_W       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_READ2 = 3'd2,
        S_LOAD  = 3'd3,
        S_ADD   = 3'd4,
        S_WRITE = 3'd5,
        S_END   = 3'd6
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Compare in ADDR_W+1 bits so base+offset never wraps below the inclusive end address.
    function automatic logic addr_in_range(
        input logic [ADDR_W-1:0] base,
        input logic [1:0]        offset,
        input logic [ADDR_W-1:0] last
    );
        return (({1'b0, base} + (ADDR_W + 1)'(offset)) <= {1'b0, last});
    endfunction

endpackage

// File: rtl/calculator_engine_chunk_adder.sv
// One DATA_W-bit adder slice with optional B inversion; the engine time-multiplexes it over the chunks.
module chunk_adder
    import calculator_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              invert_b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [DATA_W-1:0] b_eff_s;
    logic [DATA_W:0]   total_s;

    // Slice add: a + (b or ~b) + cin, carry out on the extra MSB.
    always_comb begin
        b_eff_s = '0;
        if (invert_b) begin
            b_eff_s = ~b;
        end else begin
            b_eff_s = b;
        end
        total_s = {1'b0, a} + {1'b0, b_eff_s} + {{DATA_W{1'b0}}, cin};
        sum     = total_s[DATA_W-1:0];
        cout    = total_s[DATA_W];
    end

endmodule

// File: rtl/calculator_engine.sv
// SRAM-to-SRAM add/sub engine: reads operand pairs, adds them chunk by chunk, writes one word per pair.
// Build option CARRY_CHAIN_EN: chain chunk carries into one full-width add; otherwise independent SIMD lanes.
module calculator_engine
    import calculator_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     op_i,
    input  logic [ADDR_W-1:0]        rd_start_i,
    input  logic [ADDR_W-1:0]        rd_end_i,
    input  logic [ADDR_W-1:0]        wr_start_i,
    output logic                     mem_rd_en_o,
    output logic                     mem_wr_en_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [MEM_WORD_SIZE-1:0] mem_wdata_o,
    input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     carry_o
);

    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

    state_t                   state_r;
    op_t                      op_r;
    logic [ADDR_W-1:0]        rd_end_r;
    logic [ADDR_W-1:0]        rp_r;
    logic [ADDR_W-1:0]        wp_r;
    logic [MEM_WORD_SIZE-1:0] a_r;
    logic [MEM_WORD_SIZE-1:0] b_r;
    logic [MEM_WORD_SIZE-1:0] res_r;
    logic                     has_b_r;
    logic [CHUNK_W-1:0]       k_r;
`ifdef CARRY_CHAIN_EN
    logic                     cin_r;
`else
    logic                     carry_acc_r;
`endif

    logic                     rd_en_r;
    logic                     wr_en_r;
    logic [ADDR_W-1:0]        addr_r;
    logic [MEM_WORD_SIZE-1:0] wdata_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     carry_r;

    logic                     invert_s;
    logic                     cin_s;
    logic [DATA_W-1:0]        a_chunk_s;
    logic [DATA_W-1:0]        b_chunk_s;
    logic [DATA_W-1:0]        sum_s;
    logic                     cout_s;
    logic [MEM_WORD_SIZE-1:0] res_s;
    logic                     carry_next_s;
    logic                     has_b_s;
    logic                     more_pairs_s;

    chunk_adder u_chunk_adder (
        .a        (a_chunk_s),
        .b        (b_chunk_s),
        .invert_b (invert_s),
        .cin      (cin_s),
        .sum      (sum_s),
        .cout     (cout_s)
    );

    // Select the active chunk, merge its sum into the result and form carry-in / status.
    always_comb begin
        invert_s     = (op_r == OP_SUB);
        a_chunk_s    = a_r[k_r*DATA_W +: DATA_W];
        b_chunk_s    = b_r[k_r*DATA_W +: DATA_W];
        res_s        = res_r;
        res_s[k_r*DATA_W +: DATA_W] = sum_s;
        has_b_s      = addr_in_range(rp_r, 2'd1, rd_end_r);
        more_pairs_s = addr_in_range(rp_r, 2'd2, rd_end_r);
`ifdef CARRY_CHAIN_EN
        cin_s        = cin_r;
        carry_next_s = cout_s;
`else
        cin_s        = invert_s;
        carry_next_s = carry_acc_r | cout_s;
`endif
    end

    // Control FSM, datapath registers and registered SRAM/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            op_r     <= OP_ADD;
            rd_end_r <= '0;
            rp_r     <= '0;
            wp_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            res_r    <= '0;
            has_b_r  <= 1'b0;
            k_r      <= '0;
`ifdef CARRY_CHAIN_EN
            cin_r    <= 1'b0;
`else
            carry_acc_r <= 1'b0;
`endif
            rd_en_r  <= 1'b0;
            wr_en_r  <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            carry_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        op_r     <= op_t'(op_i);
                        rd_end_r <= rd_end_i;
                        rp_r     <= rd_start_i;
                        wp_r     <= wr_start_i;
                        busy_r   <= 1'b1;
                        if (rd_start_i > rd_end_i) begin
                            state_r <= S_END;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= S_READ;
                            rd_en_r <= 1'b1;
                            addr_r  <= rd_start_i;
                        end
                    end
                end
                S_READ: begin
                    // Second operand is only fetched when it lies inside the range.
                    state_r <= S_READ2;
                    rd_en_r <= has_b_s;
                    addr_r  <= rp_r + ADDR_W'(1);
                    has_b_r <= has_b_s;
                end
                S_READ2: begin
                    state_r <= S_LOAD;
                    a_r     <= mem_rdata_i;
                    rd_en_r <= 1'b0;
                end
                S_LOAD: begin
                    state_r <= S_ADD;
                    b_r     <= has_b_r ? mem_rdata_i : '0;
                    k_r     <= '0;
`ifdef CARRY_CHAIN_EN
                    cin_r   <= invert_s;
`else
                    carry_acc_r <= 1'b0;
`endif
                end
                S_ADD: begin
                    res_r <= res_s;
`ifdef CARRY_CHAIN_EN
                    cin_r <= cout_s;
`else
                    carry_acc_r <= carry_acc_r | cout_s;
`endif
                    if (k_r == LAST_CHUNK) begin
                        state_r <= S_WRITE;
                        wr_en_r <= 1'b1;
                        addr_r  <= wp_r;
                        wdata_r <= res_s;
                        carry_r <= carry_next_s;
                    end else begin
                        k_r <= k_r + CHUNK_W'(1);
                    end
                end
                S_WRITE: begin
                    wr_en_r <= 1'b0;
                    rp_r    <= rp_r + ADDR_W'(2);
                    wp_r    <= wp_r + ADDR_W'(1);
                    if (more_pairs_s) begin
                        state_r <= S_READ;
                        rd_en_r <= 1'b1;
                        addr_r  <= rp_r + ADDR_W'(2);
                    end else begin
                        state_r <= S_END;
                        done_r  <= 1'b1;
                    end
                end
                S_END: begin
                    state_r <= S_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    rd_en_r <= 1'b0;
                    wr_en_r <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_en_o = rd_en_r;
    assign mem_wr_en_o = wr_en_r;
    assign mem_addr_o  = addr_r;
    assign mem_wdata_o = wdata_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign carry_o     = carry_r;

endmodule

// File: tb/tb_calculator_engine.sv
// Directed bench for calculator_engine with a behavioural single-port SRAM and write/read logging.
module tb_calculator_engine;
    import calculator_pkg::*;

    localparam int PAIR_CYC = NUM_CHUNKS + 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start_i;
    logic                     op_i;
    logic [ADDR_W-1:0]        rd_start_i;
    logic [ADDR_W-1:0]        rd_end_i;
    logic [ADDR_W-1:0]        wr_start_i;
    logic                     mem_rd_en_o;
    logic                     mem_wr_en_o;
    logic [ADDR_W-1:0]        mem_addr_o;
    logic [MEM_WORD_SIZE-1:0] mem_wdata_o;
    logic [MEM_WORD_SIZE-1:0] mem_rdata_i;
    logic                     busy_o;
    logic                     done_o;
    logic                     carry_o;

    logic [MEM_WORD_SIZE-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0]        wlog_addr [0:63];
    logic [MEM_WORD_SIZE-1:0] wlog_data [0:63];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int overlap_cnt = 0;
    int checks = 0;
    int errors = 0;

    calculator_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .op_i        (op_i),
        .rd_start_i  (rd_start_i),
        .rd_end_i    (rd_end_i),
        .wr_start_i  (wr_start_i),
        .mem_rd_en_o (mem_rd_en_o),
        .mem_wr_en_o (mem_wr_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .carry_o     (carry_o)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, logs every write and read strobe.
    always @(posedge clk) begin
        if (mem_rd_en_o) begin
            mem_rdata_i <= mem[mem_addr_o];
            rd_cnt      <= rd_cnt + 1;
        end
        if (mem_wr_en_o) begin
            mem[mem_addr_o] <= mem_wdata_o;
            if (wr_cnt < 64) begin
                wlog_addr[wr_cnt] <= mem_addr_o;
                wlog_data[wr_cnt] <= mem_wdata_o;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_rd_en_o && mem_wr_en_o) begin
            overlap_cnt <= overlap_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Launch a run at a falling edge and count cycles (start cycle = 1) until done_o is seen.
    task automatic run(input logic op, input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] re,
                       input logic [ADDR_W-1:0] ws, output int lat);
        logic seen;
        @(negedge clk);
        start_i = 1'b1; op_i = op; rd_start_i = rs; rd_end_i = re; wr_start_i = ws;
        lat = 1;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) start_i = 1'b0;
            lat++;
            if (done_o) seen = 1'b1;
        end
        if (!seen) lat = -1;
    endtask

    typedef struct {
        string             name;
        logic              op;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] ws;
        logic [63:0]       a;
        logic [63:0]       b;
        logic [63:0]       exp;
        logic              exp_c;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat;
        int base;
        int rbase;
        logic seen;

`ifdef CARRY_CHAIN_EN
        vecs[0] = '{"add_cross_carry", 1'b0, 10'd0,  10'd500, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 1'b0};
        vecs[1] = '{"sub_borrow",      1'b1, 10'd10, 10'd501, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[3] = '{"add_all_ones",    1'b0, 10'd30, 10'd503, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1};
        vecs[5] = '{"sub_cross",       1'b1, 10'd50, 10'd505, 64'h0000_0001_0000_0000, 64'h1, 64'h0000_0000_FFFF_FFFF, 1'b1};
        vecs[6] = '{"add_msb_both",    1'b0, 10'd60, 10'd506, 64'h8000_0000_8000_0000, 64'h8000_0000_8000_0000, 64'h0000_0001_0000_0000, 1'b1};
`else
        vecs[0] = '{"add_cross_carry", 1'b0, 10'd0,  10'd500, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0, 1'b1};
        vecs[1] = '{"sub_borrow",      1'b1, 10'd10, 10'd501, 64'h5, 64'h7, 64'h0000_0000_FFFF_FFFE, 1'b1};
        vecs[3] = '{"add_all_ones",    1'b0, 10'd30, 10'd503, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'hFFFF_FFFF_0000_0000, 1'b1};
        vecs[5] = '{"sub_cross",       1'b1, 10'd50, 10'd505, 64'h0000_0001_0000_0000, 64'h1, 64'h0000_0001_FFFF_FFFF, 1'b1};
        vecs[6] = '{"add_msb_both",    1'b0, 10'd60, 10'd506, 64'h8000_0000_8000_0000, 64'h8000_0000_8000_0000, 64'h0, 1'b1};
`endif
        vecs[2] = '{"add_plain",       1'b0, 10'd20, 10'd502, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 64'h2345_6789_ABCD_F001, 1'b0};
        vecs[4] = '{"sub_no_borrow",   1'b1, 10'd40, 10'd504, 64'h7, 64'h5, 64'h2, 1'b1};

        rst_n = 1'b0; start_i = 1'b0; op_i = 1'b0;
        rd_start_i = '0; rd_end_i = '0; wr_start_i = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_rd_en", 64'(mem_rd_en_o), 64'h0);
        check("rst_wr_en", 64'(mem_wr_en_o), 64'h0);
        check("rst_addr",  64'(mem_addr_o), 64'h0);
        check("rst_wdata", mem_wdata_o, 64'h0);
        check("rst_busy",  64'(busy_o), 64'h0);
        check("rst_done",  64'(done_o), 64'h0);
        check("rst_carry", 64'(carry_o), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-pair vectors.
        for (int v = 0; v < 7; v++) begin
            mem[vecs[v].rs] = vecs[v].a;
            mem[vecs[v].rs + 10'd1] = vecs[v].b;
            base = wr_cnt;
            run(vecs[v].op, vecs[v].rs, vecs[v].rs + 10'd1, vecs[v].ws, lat);
            check({vecs[v].name, "_latency"}, 64'(lat), 64'(PAIR_CYC + 2));
            check({vecs[v].name, "_nwrites"}, 64'(wr_cnt - base), 64'h1);
            check({vecs[v].name, "_waddr"}, 64'(wlog_addr[base]), 64'(vecs[v].ws));
            check({vecs[v].name, "_wdata"}, wlog_data[base], vecs[v].exp);
            check({vecs[v].name, "_carry"}, 64'(carry_o), 64'(vecs[v].exp_c));
            @(negedge clk);
            check({vecs[v].name, "_done_pulse"}, 64'(done_o), 64'h0);
            check({vecs[v].name, "_idle"}, 64'(busy_o), 64'h0);
        end

        // Odd-length range: last word is paired with zero, no read past the end.
        mem[0] = 64'h1; mem[1] = 64'h2;
        mem[2] = 64'h0000_0001_0000_0000; mem[3] = 64'h5;
        mem[4] = 64'hDEAD_BEEF_00C0_FFEE;
        base = wr_cnt; rbase = rd_cnt;
        run(1'b0, 10'd0, 10'd4, 10'd700, lat);
        check("odd_latency", 64'(lat), 64'(3 * PAIR_CYC + 2));
        check("odd_nwrites", 64'(wr_cnt - base), 64'h3);
        check("odd_nreads", 64'(rd_cnt - rbase), 64'h5);
        check("odd_addr0", 64'(wlog_addr[base]), 64'd700);
        check("odd_addr2", 64'(wlog_addr[base + 2]), 64'd702);
        check("odd_data0", wlog_data[base], 64'h3);
        check("odd_data1", wlog_data[base + 1], 64'h0000_0001_0000_0005);
        check("odd_data2", wlog_data[base + 2], 64'hDEAD_BEEF_00C0_FFEE);
        check("odd_carry", 64'(carry_o), 64'h0);

        // Empty range goes straight to done.
        base = wr_cnt; rbase = rd_cnt;
        run(1'b0, 10'd8, 10'd3, 10'd800, lat);
        check("empty_latency", 64'(lat), 64'h2);
        check("empty_nwrites", 64'(wr_cnt - base), 64'h0);
        check("empty_nreads", 64'(rd_cnt - rbase), 64'h0);

        // Reset during the add phase of the second pair.
        mem[20] = 64'h7; mem[21] = 64'h5; mem[22] = 64'h9; mem[23] = 64'h4;
        base = wr_cnt;
        @(negedge clk);
        start_i = 1'b1; op_i = 1'b1; rd_start_i = 10'd20; rd_end_i = 10'd23; wr_start_i = 10'd600;
        for (int i = 0; i < PAIR_CYC + 4; i++) begin
            @(negedge clk);
            if (i == 0) start_i = 1'b0;
        end
        check("rstmid_busy_before", 64'(busy_o), 64'h1);
        check("rstmid_pair1_written", 64'(wr_cnt - base), 64'h1);
        check("rstmid_pair1_data", wlog_data[base], 64'h2);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_rd_en", 64'(mem_rd_en_o), 64'h0);
        check("rstmid_wr_en", 64'(mem_wr_en_o), 64'h0);
        check("rstmid_addr", 64'(mem_addr_o), 64'h0);
        check("rstmid_wdata", mem_wdata_o, 64'h0);
        check("rstmid_busy", 64'(busy_o), 64'h0);
        check("rstmid_done", 64'(done_o), 64'h0);
        check("rstmid_carry", 64'(carry_o), 64'h0);
        rbase = rd_cnt;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rstmid_no_pair2_write", 64'(wr_cnt - base), 64'h1);
        check("rstmid_no_reads", 64'(rd_cnt - rbase), 64'h0);

        // Start pulsed while busy is ignored; write pointer wraps past the top address.
        mem[30] = 64'h0000_0010_0000_0020; mem[31] = 64'h0000_0001_0000_0002;
        mem[32] = 64'h0000_0100_0000_0200; mem[33] = 64'h0000_0300_0000_0400;
        base = wr_cnt;
        @(negedge clk);
        start_i = 1'b1; op_i = 1'b0; rd_start_i = 10'd30; rd_end_i = 10'd33; wr_start_i = 10'h3FF;
        lat = 1;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (i == 0) start_i = 1'b0;
            if (i == 3) begin
                start_i = 1'b1; op_i = 1'b1; rd_start_i = 10'd100; rd_end_i = 10'd101; wr_start_i = 10'd200;
            end
            if (i == 4) start_i = 1'b0;
            if (done_o) seen = 1'b1;
        end
        if (!seen) lat = -1;
        check("wrap_latency", 64'(lat), 64'(2 * PAIR_CYC + 2));
        repeat (20) @(negedge clk);
        check("wrap_nwrites", 64'(wr_cnt - base), 64'h2);
        check("wrap_addr0", 64'(wlog_addr[base]), 64'h3FF);
        check("wrap_addr1", 64'(wlog_addr[base + 1]), 64'h000);
        check("wrap_data0", wlog_data[base], 64'h0000_0011_0000_0022);
        check("wrap_data1", wlog_data[base + 1], 64'h0000_0400_0000_0600);
        check("wrap_idle_after", 64'(busy_o), 64'h0);

        check("rd_wr_overlap", 64'(overlap_cnt), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
